conv_enc_block_sched: RTL and testbench
=======================================

# conv_enc_block_sched

Block-level scheduler for the parallel convolutional encoder. Accepts one code-block request at a time and waits until the input byte FIFO holds a complete block. It then starts the encoder, waits for its completion strobe, and drains the three encoded subblock FIFOs in lock-step onto a valid/ready output stream. It sits between the host-side packet logic and `convEncoder_par`, and is the only agent that drives the encoder's start, length, tail and subblock-read controls.

## Interface
- `SHORT_BYTES`, 132: bytes per short block (1056 bits), `blk_len_sel=0`
- `LONG_BYTES`, 768: bytes per long block (6144 bits), `blk_len_sel=1`
- `TIMEOUT`, 4095: max cycles in ENCODE awaiting `enc_done`
- `CNT_W`, 10: width of byte counters and `in_usedw`
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `blk_req`  in  1  request to encode one block; held until `blk_ack`
- `blk_len_sel`  in  1  block size select, sampled with `blk_ack`
- `tail_in`  in  8  tail byte for the block, sampled with `blk_ack`
- `in_usedw`  in  CNT_W  fill level of the encoder's input byte FIFO
- `enc_data_valid`  out  1  one-cycle start pulse to the encoder
- `enc_code_block_length`  out  1  latched `blk_len_sel`
- `enc_tail_byte`  out  8  latched `tail_in`
- `enc_done`  in  1  encoder `computation_done` (level or pulse)
- `enc_rdreq_subblock`  out  1  pops one byte from each of the three subblock FIFOs
- `enc_q0`, `enc_q1`, `enc_q2`  in  8 each  subblock FIFO outputs, valid 1 cycle after rdreq
- `out_valid`  out  1  output triple valid
- `out_ready`  in  1  downstream accept
- `out_d0`, `out_d1`, `out_d2`  out  8 each  output bytes
- `out_last`  out  1  marks the final triple of the block
- `blk_ack`  out  1  one-cycle acceptance of `blk_req`
- `busy`  out  1  high in every state except IDLE
- `err_timeout`  out  1  sticky; cleared only by reset
- `blk_count`  out  16  completed blocks, wraps at 65535→0

## Operation
- FSM states: IDLE, WAIT_FILL, START, ENCODE, DRAIN, FLUSH.
- **IDLE:** if `blk_req`, pulse `blk_ack`, latch length and tail, set `nbytes` (132 or 768), then go to WAIT_FILL.
- **WAIT_FILL:** when `in_usedw >= nbytes`, go to START.
- **START:** `enc_data_valid=1` for exactly one cycle, then go to ENCODE.
- **ENCODE:**
  - Wait for `enc_done`. The timeout counter resets on entry.
  - If `enc_done` is seen, go to DRAIN with `rd_left = nbytes`.
  - If the counter reaches `TIMEOUT`, set `err_timeout` and go to IDLE. `blk_count` is not incremented.
- **DRAIN:**
  - Assert `enc_rdreq_subblock` when `rd_left > 0` and `credit > 0`.
  - `credit` is the number of free skid entries minus reads in flight, with a maximum of 2.
  - Each rdreq decrements `rd_left`.
  - Returned triples enter the skid buffer. The triple from the read issued at `rd_left == 1` is tagged `last`.
  - When `rd_left == 0`, go to FLUSH.
- **FLUSH:** when the `last` triple handshakes (`out_valid & out_ready & out_last`), increment `blk_count` and go to IDLE.
- `blk_req` is ignored outside IDLE, and `blk_ack` never asserts outside IDLE.
- `enc_code_block_length` and `enc_tail_byte` stay stable from ack until the next ack.
- Reset values:
  - All outputs are 0, the FSM is in IDLE and the skid buffer is empty.
  - This holds at any point, including mid-DRAIN; in-flight reads are discarded.

## Timing
- Ack to `enc_data_valid`: 2 cycles minimum (IDLE→WAIT_FILL→START), when the FIFO is already full enough.
- Read latency: rdreq at cycle t, `enc_q*` sampled at the end of t+1, `out_valid` at t+2.
- With `out_ready` held high, DRAIN sustains one triple per cycle. `nbytes` triples finish by `nbytes+2` cycles after DRAIN entry.
- Backpressure:
  - While `out_valid & !out_ready`, the output bytes are held stable.
  - At most 2 triples are buffered or in flight; overflow is impossible by construction.
- If `enc_done` and the timeout expire in the same cycle, `enc_done` wins.
- Back-to-back blocks: a new `blk_req` can be acked the cycle after FLUSH exits.

## Structure
- Shared package `conv_enc_pkg`:
  - state enum;
  - `SHORT_BYTES` and `LONG_BYTES` constants;
  - function `blk_bytes(len_sel)`.
- Sub-module `out_skid2`: 2-entry, 25-bit (24 data + last) valid/ready FIFO with a `free_cnt` output used for credit.

## Test plan
- Short block, `tail_in=0xA5`, `in_usedw=132`, `out_ready=1`: one `enc_data_valid` pulse with `enc_tail_byte=0xA5` and `enc_code_block_length=0`; after `enc_done`, exactly 132 triples; `out_last` only on the 132nd; `blk_count=1`.
- Long block, `in_usedw` ramping 0→768 by one per cycle: START occurs only in the cycle after `in_usedw` reaches 768; then 768 triples with rdreq count = 768.
- Random `out_ready` (50%) during a long drain: no triple lost or duplicated; data is held stable while stalled; rdreq never asserts with credit 0.
- `enc_done` withheld for 4095 cycles: `err_timeout=1`, return to IDLE, `blk_count` unchanged; the next block then completes normally with `err_timeout` still 1.
- `reset` asserted low in DRAIN after 50 triples: all outputs are 0 immediately; after release, a fresh short block produces 132 triples.
- `blk_req` held high for two blocks: two `blk_ack` pulses separated by a full block; `blk_count=2`.

Source files
------------

// File: rtl/conv_enc_block_sched_pkg.sv
// Shared types, block sizes and helpers for the convolutional encoder block scheduler.
package conv_enc_pkg;

   localparam int SHORT_BYTES = 132;
   localparam int LONG_BYTES  = 768;
   localparam int TIMEOUT     = 4095;
   localparam int CNT_W       = 10;
   localparam int TMO_W       = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_FILL,
      START,
      ENCODE,
      DRAIN,
      FLUSH
   } sched_state_t;

   function automatic logic [CNT_W-1:0] blk_bytes(input logic len_sel);
      return len_sel ? CNT_W'(LONG_BYTES) : CNT_W'(SHORT_BYTES);
   endfunction

endpackage

// File: rtl/conv_enc_block_sched_skid.sv
// Two-entry valid/ready FIFO holding encoded triples plus their last flag.
// free_cnt tells the scheduler how many reads it may safely have outstanding.
module out_skid2
   import conv_enc_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic [24:0] push_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [24:0] out_data,
   output logic [1:0]  free_cnt
);

   logic [24:0] mem [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;
   logic        pop;

   assign out_valid = (count != 2'd0);
   assign pop       = out_valid & out_ready;
   assign out_data  = mem[rd_ptr];

   // A slot vacated by this cycle's pop is already usable, which lets a drain run at one triple per cycle.
   assign free_cnt  = 2'd2 - count + {1'b0, pop};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/conv_enc_block_sched.sv
// Block-level scheduler: waits for a full input block, starts the encoder, then
// drains the three subblock FIFOs in lock-step onto a valid/ready stream.
module conv_enc_block_sched
   import conv_enc_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             blk_req,
   input  logic             blk_len_sel,
   input  logic [7:0]       tail_in,
   input  logic [CNT_W-1:0] in_usedw,
   output logic             enc_data_valid,
   output logic             enc_code_block_length,
   output logic [7:0]       enc_tail_byte,
   input  logic             enc_done,
   output logic             enc_rdreq_subblock,
   input  logic [7:0]       enc_q0,
   input  logic [7:0]       enc_q1,
   input  logic [7:0]       enc_q2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_d0,
   output logic [7:0]       out_d1,
   output logic [7:0]       out_d2,
   output logic             out_last,
   output logic             blk_ack,
   output logic             busy,
   output logic             err_timeout,
   output logic [15:0]      blk_count
);

   sched_state_t     state_q;
   sched_state_t     state_d;
   logic [CNT_W-1:0] nbytes;
   logic [CNT_W-1:0] rd_left;
   logic [TMO_W-1:0] tmo_cnt;
   logic             rd_pend;
   logic             rd_last_pend;
   logic [1:0]       free_cnt;
   logic [1:0]       credit;
   logic             skid_valid;
   logic [24:0]      skid_data;
   logic             tmo_hit;
   logic             blk_done;

   // The read issued last cycle lands in the skid this cycle, so it already owns a slot.
   assign credit = (free_cnt > {1'b0, rd_pend}) ? (free_cnt - {1'b0, rd_pend}) : 2'd0;

   out_skid2 u_skid (
      .clk       (clk),
      .reset     (reset),
      .push      (rd_pend),
      .push_data ({rd_last_pend, enc_q2, enc_q1, enc_q0}),
      .out_valid (skid_valid),
      .out_ready (out_ready),
      .out_data  (skid_data),
      .free_cnt  (free_cnt)
   );

   assign out_valid = skid_valid;
   assign out_d0    = skid_data[7:0];
   assign out_d1    = skid_data[15:8];
   assign out_d2    = skid_data[23:16];
   assign out_last  = skid_data[24];
   assign busy      = (state_q != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // enc_done takes priority over an expiring timeout in the same cycle.
   always_comb begin
      state_d            = state_q;
      blk_ack            = 1'b0;
      enc_data_valid     = 1'b0;
      enc_rdreq_subblock = 1'b0;
      tmo_hit            = 1'b0;
      blk_done           = 1'b0;
      case (state_q)
         IDLE: begin
            if (blk_req) begin
               blk_ack = 1'b1;
               state_d = WAIT_FILL;
            end
         end
         WAIT_FILL: begin
            if (in_usedw >= nbytes) begin
               state_d = START;
            end
         end
         START: begin
            enc_data_valid = 1'b1;
            state_d        = ENCODE;
         end
         ENCODE: begin
            if (enc_done) begin
               state_d = DRAIN;
            end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
               tmo_hit = 1'b1;
               state_d = IDLE;
            end
         end
         DRAIN: begin
            enc_rdreq_subblock = (rd_left != '0) && (credit != 2'd0);
            if (rd_left == '0) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (skid_valid && out_ready && skid_data[24]) begin
               blk_done = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Block parameters are latched at ack and held until the next ack.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         nbytes                <= '0;
         enc_code_block_length <= 1'b0;
         enc_tail_byte         <= 8'd0;
      end else if (blk_ack) begin
         nbytes                <= blk_bytes(blk_len_sel);
         enc_code_block_length <= blk_len_sel;
         enc_tail_byte         <= tail_in;
      end
   end

   // Read bookkeeping: rd_pend marks a triple arriving on enc_q* this cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_left      <= '0;
         tmo_cnt      <= '0;
         rd_pend      <= 1'b0;
         rd_last_pend <= 1'b0;
         err_timeout  <= 1'b0;
         blk_count    <= 16'd0;
      end else begin
         rd_pend      <= enc_rdreq_subblock;
         rd_last_pend <= enc_rdreq_subblock && (rd_left == CNT_W'(1));
         if (state_q == START) begin
            tmo_cnt <= '0;
         end else if (state_q == ENCODE) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         end
         if ((state_q == ENCODE) && enc_done) begin
            rd_left <= nbytes;
         end else if (enc_rdreq_subblock) begin
            rd_left <= rd_left - CNT_W'(1);
         end
         if (tmo_hit) begin
            err_timeout <= 1'b1;
         end
         if (blk_done) begin
            blk_count <= blk_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_conv_enc_block_sched.sv
// Directed-plus-random bench for conv_enc_block_sched: models the encoder's subblock
// FIFOs as queues and expects the output stream to replay them in order.
module tb_conv_enc_block_sched;
   import conv_enc_pkg::*;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             blk_req = 1'b0;
   logic             blk_len_sel = 1'b0;
   logic [7:0]       tail_in = 8'd0;
   logic [CNT_W-1:0] in_usedw = '0;
   logic             enc_data_valid;
   logic             enc_code_block_length;
   logic [7:0]       enc_tail_byte;
   logic             enc_done = 1'b0;
   logic             enc_rdreq_subblock;
   logic [7:0]       enc_q0 = 8'd0;
   logic [7:0]       enc_q1 = 8'd0;
   logic [7:0]       enc_q2 = 8'd0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [7:0]       out_d0;
   logic [7:0]       out_d1;
   logic [7:0]       out_d2;
   logic             out_last;
   logic             blk_ack;
   logic             busy;
   logic             err_timeout;
   logic [15:0]      blk_count;

   int          n_assert = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [23:0] enc_fifo[$];
   logic [24:0] exp_q[$];
   int          tot_rd = 0;
   int          tot_hs = 0;
   int          blk_rd, blk_hs, blk_start, blk_ack_cnt;
   int          ack_cycle, start_cycle, last_hs_cycle, done_cycle;
   logic        ack_now, start_now, last_now;
   int          usedw_this = 0;
   int          usedw_last = 0;
   logic        stall_prev = 1'b0;
   logic [24:0] held = '0;
   int          exp_count = 0;

   conv_enc_block_sched dut (
      .clk                   (clk),
      .reset                 (reset),
      .blk_req               (blk_req),
      .blk_len_sel           (blk_len_sel),
      .tail_in               (tail_in),
      .in_usedw              (in_usedw),
      .enc_data_valid        (enc_data_valid),
      .enc_code_block_length (enc_code_block_length),
      .enc_tail_byte         (enc_tail_byte),
      .enc_done              (enc_done),
      .enc_rdreq_subblock    (enc_rdreq_subblock),
      .enc_q0                (enc_q0),
      .enc_q1                (enc_q1),
      .enc_q2                (enc_q2),
      .out_valid             (out_valid),
      .out_ready             (out_ready),
      .out_d0                (out_d0),
      .out_d1                (out_d1),
      .out_d2                (out_d2),
      .out_last              (out_last),
      .blk_ack               (blk_ack),
      .busy                  (busy),
      .err_timeout           (err_timeout),
      .blk_count             (blk_count)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // One clock: sample at the falling edge, then serve any subblock read after the rising edge.
   task automatic step();
      logic        rd_s;
      logic        hs;
      logic [24:0] obs_t;
      @(negedge clk);
      cyc++;
      usedw_last = usedw_this;
      usedw_this = int'(in_usedw);
      obs_t     = {out_last, out_d2, out_d1, out_d0};
      hs        = out_valid && out_ready;
      rd_s      = enc_rdreq_subblock;
      ack_now   = blk_ack;
      start_now = enc_data_valid;
      last_now  = hs && out_last;
      if (stall_prev) begin
         check_output("stall_valid_held", out_valid, 1);
         check_output("stall_data_held", obs_t, held);
      end
      stall_prev = out_valid && !out_ready;
      held       = obs_t;
      if (hs) begin
         tot_hs++;
         blk_hs++;
         check_output("triple_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) check_output("triple_value", obs_t, exp_q.pop_front());
         if (out_last) last_hs_cycle = cyc;
      end
      if (rd_s) begin
         check_output("rd_with_credit", (tot_rd - tot_hs) <= 1, 1);
         tot_rd++;
         blk_rd++;
      end
      if (ack_now) begin
         check_output("ack_only_idle", busy, 0);
         ack_cycle = cyc;
         blk_ack_cnt++;
      end
      if (start_now) begin
         start_cycle = cyc;
         blk_start++;
      end
      @(posedge clk);
      #1;
      if (rd_s) begin
         check_output("rd_within_block", enc_fifo.size() != 0, 1);
         if (enc_fifo.size() != 0) {enc_q2, enc_q1, enc_q0} = enc_fifo.pop_front();
      end
   endtask

   task automatic apply_stimulus(input logic len_sel, input logic [7:0] tail, input logic ramp,
                                 input int ready_pct, input logic hold_req, input logic check_b2b,
                                 input int abort_after, input logic withhold_done);
      int          n;
      int          budget;
      int          prev_last_hs;
      logic [31:0] r;
      n            = len_sel ? LONG_BYTES : SHORT_BYTES;
      prev_last_hs = last_hs_cycle;
      blk_rd = 0; blk_hs = 0; blk_start = 0; blk_ack_cnt = 0;
      out_ready   = 1'b1;
      blk_req     = 1'b1;
      blk_len_sel = len_sel;
      tail_in     = tail;
      in_usedw    = ramp ? '0 : CNT_W'(n);
      budget = 0;
      do begin
         step();
         budget++;
      end while (!ack_now && budget < 8);
      check_output("ack_seen", ack_now, 1);
      if (check_b2b) check_output("b2b_ack_cycle", ack_cycle, prev_last_hs + 1);
      if (!hold_req) blk_req = 1'b0;
      blk_len_sel = ~len_sel;
      tail_in     = ~tail;

      budget = 0;
      while (!start_now && budget < 1000) begin
         if (ramp && int'(in_usedw) < n) in_usedw = in_usedw + CNT_W'(1);
         step();
         budget++;
      end
      check_output("start_seen", start_now, 1);
      check_output("start_usedw", usedw_last, n);
      if (!ramp) check_output("ack_to_start", start_cycle - ack_cycle, 2);
      check_output("tail_latched", enc_tail_byte, tail);
      check_output("len_latched", enc_code_block_length, len_sel);

      for (int i = 0; i < n; i++) begin
         r = $urandom;
         enc_fifo.push_back(r[23:0]);
         exp_q.push_back({(i == n - 1), r[23:0]});
      end

      if (withhold_done) begin
         for (int i = 0; i < 4000; i++) step();
         check_output("timeout_not_early", err_timeout, 0);
         budget = 0;
         while (busy && budget < 200) begin
            step();
            budget++;
         end
         check_output("timeout_idle", busy, 0);
         check_output("timeout_flag", err_timeout, 1);
         check_output("timeout_count_kept", blk_count, exp_count);
         check_output("timeout_no_reads", blk_rd, 0);
         enc_fifo.delete();
         exp_q.delete();
         blk_req = 1'b0;
         return;
      end

      for (int i = 0; i < int'($urandom_range(1, 20)); i++) step();
      enc_done = 1'b1;
      step();
      done_cycle = cyc;
      enc_done = 1'b0;

      budget = 0;
      while (blk_hs < n && budget < 4 * n + 100) begin
         out_ready = ($urandom_range(0, 99) < ready_pct);
         step();
         budget++;
         if (abort_after > 0 && blk_hs >= abort_after) return;
      end
      out_ready = 1'b1;
      check_output("triple_count", blk_hs, n);
      check_output("rdreq_count", blk_rd, n);
      check_output("last_on_final", last_now, 1);
      check_output("start_pulses", blk_start, 1);
      check_output("ack_pulses", blk_ack_cnt, 1);
      check_output("exp_drained", exp_q.size(), 0);
      if (ready_pct >= 100) check_output("drain_rate", (last_hs_cycle - done_cycle - 1) <= n + 2, 1);
      exp_count++;
      check_output("blk_count", blk_count, exp_count);
   endtask

   task automatic check_all_zero(input string tag);
      check_output({tag, "_outs"}, {out_valid, out_last, blk_ack, busy, enc_data_valid,
                                    enc_rdreq_subblock, err_timeout, enc_code_block_length}, 0);
      check_output({tag, "_data"}, {out_d2, out_d1, out_d0}, 0);
      check_output({tag, "_tail"}, enc_tail_byte, 0);
      check_output({tag, "_count"}, blk_count, 0);
   endtask

   initial begin
      step();
      step();
      check_all_zero("reset");
      reset = 1'b1;
      step();

      $display("[TB] short block, full FIFO");
      apply_stimulus(1'b0, 8'hA5, 1'b0, 100, 1'b0, 1'b0, 0, 1'b0);

      $display("[TB] long block, ramping fill level");
      apply_stimulus(1'b1, 8'h3C, 1'b1, 100, 1'b0, 1'b0, 0, 1'b0);

      $display("[TB] long block, random backpressure");
      apply_stimulus(1'b1, 8'h5E, 1'b0, 50, 1'b0, 1'b0, 0, 1'b0);

      $display("[TB] encoder timeout");
      apply_stimulus(1'b0, 8'h11, 1'b0, 100, 1'b0, 1'b0, 0, 1'b1);
      apply_stimulus(1'b0, 8'h22, 1'b0, 70, 1'b0, 1'b0, 0, 1'b0);
      check_output("timeout_sticky", err_timeout, 1);

      $display("[TB] reset during drain");
      apply_stimulus(1'b0, 8'h77, 1'b0, 100, 1'b0, 1'b0, 50, 1'b0);
      check_output("abort_in_drain", busy, 1);
      reset = 1'b0;
      #1;
      check_all_zero("mid_reset");
      enc_fifo.delete();
      exp_q.delete();
      tot_rd     = 0;
      tot_hs     = 0;
      stall_prev = 1'b0;
      exp_count  = 0;
      step();
      reset = 1'b1;
      step();
      apply_stimulus(1'b0, 8'h9B, 1'b0, 100, 1'b0, 1'b0, 0, 1'b0);

      $display("[TB] blk_req held across two blocks");
      apply_stimulus(1'b0, 8'hC3, 1'b0, 100, 1'b1, 1'b0, 0, 1'b0);
      apply_stimulus(1'b1, 8'h4D, 1'b0, 80, 1'b1, 1'b1, 0, 1'b0);
      blk_req = 1'b0;
      step();
      check_output("no_extra_ack", ack_now, 0);
      check_output("final_count", blk_count, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
